power_accum: RTL and testbench

//   Downstream of the ADC SPI sequencer. Consumes paired voltage/current

---
 rtl/power_accum_if.sv | 39 +++
 rtl/power_accum.sv | 211 +++++++++++++++++++++
 tb/tb_power_accum.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/power_accum_if.sv
// power_accum_if: sample-in / result-out bundle for power_accum.
// Optional PEAK_EN macro adds the per-window peak magnitude outputs v_pk/i_pk.
interface power_accum_if #(
    parameter int DW    = 14,
    parameter int ACC_W = 48
);
    logic                    clr;
    logic                    smp_valid;
    logic [DW-1:0]           v_smp;
    logic [DW-1:0]           i_smp;
    logic                    busy;
    logic                    res_valid;
    logic signed [ACC_W-1:0] sum_p;
    logic [ACC_W-1:0]        sum_vv;
    logic [ACC_W-1:0]        sum_ii;
    logic                    overrun;
`ifdef PEAK_EN
    logic [DW-2:0]           v_pk;
    logic [DW-2:0]           i_pk;

    modport master (
        output clr, smp_valid, v_smp, i_smp,
        input  busy, res_valid, sum_p, sum_vv, sum_ii, overrun, v_pk, i_pk
    );
    modport slave (
        input  clr, smp_valid, v_smp, i_smp,
        output busy, res_valid, sum_p, sum_vv, sum_ii, overrun, v_pk, i_pk
    );
`else
    modport master (
        output clr, smp_valid, v_smp, i_smp,
        input  busy, res_valid, sum_p, sum_vv, sum_ii, overrun
    );
    modport slave (
        input  clr, smp_valid, v_smp, i_smp,
        output busy, res_valid, sum_p, sum_vv, sum_ii, overrun
    );
`endif
endinterface

// File: rtl/power_accum.sv
// power_accum: accumulates sum(v*i), sum(v*v), sum(i*i) of offset-binary
// sample pairs over WINDOW samples using one shared signed multiplier that
// a small FSM steps through the three products. Sums latch at window end.
// Optional PEAK_EN macro adds per-window peak |v| and |i| (saturating) outputs.
module power_accum #(
    parameter int DW     = 14,
    parameter int WINDOW = 17857,
    parameter int ACC_W  = 48
) (
    input  logic         clk,
    input  logic         rst,
    power_accum_if.slave bus
);
    localparam int               CNT_W    = $clog2(WINDOW + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WINDOW - 1);

    typedef enum logic [2:0] {IDLE, MP, MV, MI, DONE} state_t;

    state_t                  state_q, state_d;
    logic signed [DW-1:0]    v_q, v_d, i_q, i_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [ACC_W-1:0] acc_p_q, acc_p_d;
    logic signed [ACC_W-1:0] acc_vv_q, acc_vv_d;
    logic signed [ACC_W-1:0] acc_ii_q, acc_ii_d;
    logic signed [ACC_W-1:0] sum_p_q, sum_p_d;
    logic [ACC_W-1:0]        sum_vv_q, sum_vv_d;
    logic [ACC_W-1:0]        sum_ii_q, sum_ii_d;
    logic                    res_valid_q, res_valid_d;
    logic                    overrun_q, overrun_d;
    logic signed [DW-1:0]    mul_a, mul_b;
    logic signed [2*DW-1:0]  prod;
    logic signed [ACC_W-1:0] prod_ext;
`ifdef PEAK_EN
    logic [DW-2:0]           v_trk_q, v_trk_d, i_trk_q, i_trk_d;
    logic [DW-2:0]           v_pk_q, v_pk_d, i_pk_q, i_pk_d;
    logic [DW-2:0]           v_abs, i_abs;
`endif

    // Offset-binary to two's complement: flipping the MSB maps midscale to 0.
    function automatic logic signed [DW-1:0] to_signed(input logic [DW-1:0] x);
        return {~x[DW-1], x[DW-2:0]};
    endfunction

`ifdef PEAK_EN
    // Magnitude in DW-1 bits; the most negative code saturates to full scale.
    function automatic logic [DW-2:0] abs_sat(input logic signed [DW-1:0] x);
        logic signed [DW-1:0] n;
        n = -x;
        if (!x[DW-1])
            return x[DW-2:0];
        else if (n[DW-1])
            return {(DW-1){1'b1}};
        else
            return n[DW-2:0];
    endfunction

    assign v_abs = abs_sat(v_q);
    assign i_abs = abs_sat(i_q);
`endif

    // Shared multiplier operand select: MP v*i, MV v*v, MI i*i.
    always_comb begin
        mul_a = v_q;
        mul_b = i_q;
        case (state_q)
            MV:      mul_b = v_q;
            MI:      mul_a = i_q;
            default: ;
        endcase
    end

    assign prod     = mul_a * mul_b;
    assign prod_ext = {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};

    // Next-state, accumulation and result latching; clr overrides everything.
    always_comb begin
        state_d     = state_q;
        v_d         = v_q;
        i_d         = i_q;
        cnt_d       = cnt_q;
        acc_p_d     = acc_p_q;
        acc_vv_d    = acc_vv_q;
        acc_ii_d    = acc_ii_q;
        sum_p_d     = sum_p_q;
        sum_vv_d    = sum_vv_q;
        sum_ii_d    = sum_ii_q;
        res_valid_d = 1'b0;
        overrun_d   = overrun_q;
`ifdef PEAK_EN
        v_trk_d     = v_trk_q;
        i_trk_d     = i_trk_q;
        v_pk_d      = v_pk_q;
        i_pk_d      = i_pk_q;
`endif
        if (bus.clr) begin
            state_d   = IDLE;
            cnt_d     = '0;
            acc_p_d   = '0;
            acc_vv_d  = '0;
            acc_ii_d  = '0;
            overrun_d = 1'b0;
`ifdef PEAK_EN
            v_trk_d   = '0;
            i_trk_d   = '0;
`endif
        end else begin
            // A strobe arriving while the multiplier is busy is dropped.
            if (bus.smp_valid && state_q != IDLE)
                overrun_d = 1'b1;
            case (state_q)
                IDLE: begin
                    if (bus.smp_valid) begin
                        v_d     = to_signed(bus.v_smp);
                        i_d     = to_signed(bus.i_smp);
                        state_d = MP;
                    end
                end
                MP: begin
                    acc_p_d = acc_p_q + prod_ext;
`ifdef PEAK_EN
                    if (v_abs > v_trk_q) v_trk_d = v_abs;
                    if (i_abs > i_trk_q) i_trk_d = i_abs;
`endif
                    state_d = MV;
                end
                MV: begin
                    acc_vv_d = acc_vv_q + prod_ext;
                    state_d  = MI;
                end
                MI: begin
                    acc_ii_d = acc_ii_q + prod_ext;
                    cnt_d    = cnt_q + 1'b1;
                    state_d  = (cnt_q == LAST_CNT) ? DONE : IDLE;
                end
                DONE: begin
                    sum_p_d     = acc_p_q;
                    sum_vv_d    = acc_vv_q;
                    sum_ii_d    = acc_ii_q;
                    res_valid_d = 1'b1;
                    acc_p_d     = '0;
                    acc_vv_d    = '0;
                    acc_ii_d    = '0;
                    cnt_d       = '0;
`ifdef PEAK_EN
                    v_pk_d      = v_trk_q;
                    i_pk_d      = i_trk_q;
                    v_trk_d     = '0;
                    i_trk_d     = '0;
`endif
                    state_d     = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State register; asynchronous reset clears everything including results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            v_q         <= '0;
            i_q         <= '0;
            cnt_q       <= '0;
            acc_p_q     <= '0;
            acc_vv_q    <= '0;
            acc_ii_q    <= '0;
            sum_p_q     <= '0;
            sum_vv_q    <= '0;
            sum_ii_q    <= '0;
            res_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef PEAK_EN
            v_trk_q     <= '0;
            i_trk_q     <= '0;
            v_pk_q      <= '0;
            i_pk_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            v_q         <= v_d;
            i_q         <= i_d;
            cnt_q       <= cnt_d;
            acc_p_q     <= acc_p_d;
            acc_vv_q    <= acc_vv_d;
            acc_ii_q    <= acc_ii_d;
            sum_p_q     <= sum_p_d;
            sum_vv_q    <= sum_vv_d;
            sum_ii_q    <= sum_ii_d;
            res_valid_q <= res_valid_d;
            overrun_q   <= overrun_d;
`ifdef PEAK_EN
            v_trk_q     <= v_trk_d;
            i_trk_q     <= i_trk_d;
            v_pk_q      <= v_pk_d;
            i_pk_q      <= i_pk_d;
`endif
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.res_valid = res_valid_q;
    assign bus.sum_p     = sum_p_q;
    assign bus.sum_vv    = sum_vv_q;
    assign bus.sum_ii    = sum_ii_q;
    assign bus.overrun   = overrun_q;
`ifdef PEAK_EN
    assign bus.v_pk      = v_pk_q;
    assign bus.i_pk      = i_pk_q;
`endif

endmodule

// File: tb/tb_power_accum.sv
// tb_power_accum: directed vector table, hand-written corner sequences and
// random stimulus checked against a timing/arithmetic model of the block.
module tb_power_accum;
    localparam int DW     = 14;
    localparam int ACC_W  = 48;
    localparam int WIN    = 4;
    localparam int BIG_W  = 2048;   // wide enough to exceed 32-bit sums with extreme samples

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    power_accum_if #(.DW(DW), .ACC_W(ACC_W)) bus ();
    power_accum_if #(.DW(DW), .ACC_W(ACC_W)) bif ();

    power_accum #(.DW(DW), .WINDOW(WIN), .ACC_W(ACC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    power_accum #(.DW(DW), .WINDOW(BIG_W), .ACC_W(ACC_W)) dut_big (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    int errs   = 0;
    int checks = 0;

    typedef struct {
        logic [DW-1:0] v;
        logic [DW-1:0] i;
        longint        p;
        longint        vv;
        longint        ii;
        longint        vpk;
        longint        ipk;
    } vec_t;
    vec_t tbl[5];

    // ---------------- reference model ----------------
    int     edge_n    = 0;
    int     free_at   = 0;     // first edge at which a strobe is accepted
    int     pend_edge = -1;    // edge at which a completed window is reported
    int     m_cnt     = 0;
    bit     m_ovr     = 0;
    bit     exp_rv    = 0;
    bit     exp_busy  = 0;
    longint m_p = 0, m_vv = 0, m_ii = 0, m_vpk = 0, m_ipk = 0;
    longint pend_p, pend_vv, pend_ii, pend_vpk, pend_ipk;
    longint exp_p = 0, exp_vv = 0, exp_ii = 0, exp_vpk = 0, exp_ipk = 0;

    function automatic longint sval(input logic [DW-1:0] x);
        return longint'(x) - 8192;
    endfunction

    function automatic longint mag(input longint x);
        longint a;
        a = (x < 0) ? -x : x;
        return (a > 8191) ? 8191 : a;
    endfunction

    task automatic model_reset();
        m_p = 0; m_vv = 0; m_ii = 0; m_vpk = 0; m_ipk = 0; m_cnt = 0; m_ovr = 0;
        exp_p = 0; exp_vv = 0; exp_ii = 0; exp_vpk = 0; exp_ipk = 0;
        pend_edge = -1; free_at = edge_n; exp_rv = 0; exp_busy = 0;
    endtask

    task automatic model_edge(input bit c, input bit s, input logic [DW-1:0] v, input logic [DW-1:0] i);
        longint a, b;
        exp_rv = 0;
        if (c) begin
            m_p = 0; m_vv = 0; m_ii = 0; m_vpk = 0; m_ipk = 0; m_cnt = 0; m_ovr = 0;
            pend_edge = -1;
            free_at   = edge_n + 1;
        end else begin
            if (pend_edge == edge_n) begin
                exp_rv = 1;
                exp_p = pend_p; exp_vv = pend_vv; exp_ii = pend_ii;
                exp_vpk = pend_vpk; exp_ipk = pend_ipk;
                pend_edge = -1;
            end
            if (s) begin
                if (edge_n >= free_at) begin
                    a = sval(v);
                    b = sval(i);
                    m_p  += a * b;
                    m_vv += a * a;
                    m_ii += b * b;
                    if (mag(a) > m_vpk) m_vpk = mag(a);
                    if (mag(b) > m_ipk) m_ipk = mag(b);
                    m_cnt++;
                    if (m_cnt == WIN) begin
                        pend_edge = edge_n + 4;
                        pend_p = m_p; pend_vv = m_vv; pend_ii = m_ii;
                        pend_vpk = m_vpk; pend_ipk = m_ipk;
                        m_p = 0; m_vv = 0; m_ii = 0; m_vpk = 0; m_ipk = 0; m_cnt = 0;
                        free_at = edge_n + 5;
                    end else begin
                        free_at = edge_n + 4;
                    end
                end else begin
                    m_ovr = 1;
                end
            end
        end
        exp_busy = (edge_n < free_at - 1);
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock: drive at negedge, sample #1 after posedge, compare against model.
    task automatic step(input bit c, input bit s, input logic [DW-1:0] v, input logic [DW-1:0] i);
        @(negedge clk);
        bus.clr       = c;
        bus.smp_valid = s;
        bus.v_smp     = v;
        bus.i_smp     = i;
        @(posedge clk);
        #1;
        edge_n++;
        model_edge(c, s, v, i);
        chk("res_valid", longint'(bus.res_valid), longint'(exp_rv));
        chk("busy", longint'(bus.busy), longint'(exp_busy));
        chk("overrun", longint'(bus.overrun), longint'(m_ovr));
        chk("sum_p", longint'($signed(bus.sum_p)), exp_p);
        chk("sum_vv", longint'(bus.sum_vv), exp_vv);
        chk("sum_ii", longint'(bus.sum_ii), exp_ii);
`ifdef PEAK_EN
        chk("v_pk", longint'(bus.v_pk), exp_vpk);
        chk("i_pk", longint'(bus.i_pk), exp_ipk);
`endif
        if (bus.res_valid)
            $display("window result: sum_p=%0d sum_vv=%0d sum_ii=%0d",
                     $signed(bus.sum_p), bus.sum_vv, bus.sum_ii);
    endtask

    // One sample followed by four idle cycles (legal spacing even at window end).
    task automatic sample5(input logic [DW-1:0] v, input logic [DW-1:0] i);
        step(0, 1, v, i);
        repeat (4) step(0, 0, '0, '0);
    endtask

    initial begin
        bit seen;
        bit c, s;
        logic [DW-1:0] rv, ri;

        tbl[0] = '{v: 14'd8292, i: 14'd8292,  p: 40000,      vv: 40000,     ii: 40000,     vpk: 100,  ipk: 100};
        tbl[1] = '{v: 14'd8292, i: 14'd8142,  p: -20000,     vv: 40000,     ii: 10000,     vpk: 100,  ipk: 50};
        tbl[2] = '{v: 14'd7892, i: 14'd8292,  p: -120000,    vv: 360000,    ii: 40000,     vpk: 300,  ipk: 100};
        tbl[3] = '{v: 14'd0,    i: 14'd16383, p: -268402688, vv: 268435456, ii: 268369924, vpk: 8191, ipk: 8191};
        tbl[4] = '{v: 14'd8192, i: 14'd8192,  p: 0,          vv: 0,         ii: 0,         vpk: 0,    ipk: 0};

        bus.clr = 0; bus.smp_valid = 0; bus.v_smp = '0; bus.i_smp = '0;
        bif.clr = 0; bif.smp_valid = 0; bif.v_smp = '0; bif.i_smp = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", longint'(bus.busy), 0);
        chk("reset_res_valid", longint'(bus.res_valid), 0);
        chk("reset_overrun", longint'(bus.overrun), 0);
        chk("reset_sum_p", longint'($signed(bus.sum_p)), 0);
        chk("reset_sum_vv", longint'(bus.sum_vv), 0);
        @(negedge clk);
        rst = 0;
        model_reset();

        // Directed vector table: four identical samples per window
        for (int k = 0; k < 5; k++) begin
            repeat (WIN) sample5(tbl[k].v, tbl[k].i);
            $display("vector %0d: v=%0d i=%0d sum_p=%0d", k, tbl[k].v, tbl[k].i, $signed(bus.sum_p));
            chk("tbl_res_valid", longint'(bus.res_valid), 1);
            chk("tbl_sum_p", longint'($signed(bus.sum_p)), tbl[k].p);
            chk("tbl_sum_vv", longint'(bus.sum_vv), tbl[k].vv);
            chk("tbl_sum_ii", longint'(bus.sum_ii), tbl[k].ii);
`ifdef PEAK_EN
            chk("tbl_v_pk", longint'(bus.v_pk), tbl[k].vpk);
            chk("tbl_i_pk", longint'(bus.i_pk), tbl[k].ipk);
`endif
        end

        // Strobe two cycles after an accepted one is dropped and sets overrun
        step(1, 0, '0, '0);
        step(0, 1, 14'd8292, 14'd8292);
        step(0, 0, '0, '0);
        step(0, 1, 14'd9192, 14'd9192);
        chk("drop_overrun", longint'(bus.overrun), 1);
        step(0, 0, '0, '0);
        repeat (3) sample5(14'd8292, 14'd8292);
        chk("drop_res_valid", longint'(bus.res_valid), 1);
        chk("drop_sum_p", longint'($signed(bus.sum_p)), 40000);
        chk("drop_sum_vv", longint'(bus.sum_vv), 40000);

        // clr after two samples discards the partial window
        step(1, 0, '0, '0);
        repeat (2) sample5(14'd8692, 14'd8692);
        step(1, 1, 14'd8692, 14'd8692);
        chk("clr_overrun", longint'(bus.overrun), 0);
        repeat (4) sample5(14'd8292, 14'd8292);
        chk("clr_res_valid", longint'(bus.res_valid), 1);
        chk("clr_sum_p", longint'($signed(bus.sum_p)), 40000);
        chk("clr_sum_ii", longint'(bus.sum_ii), 40000);

        // Asynchronous reset while in MV zeroes every output at once
        step(1, 0, '0, '0);
        step(0, 1, 14'd7892, 14'd8292);
        step(0, 0, '0, '0);
        rst = 1;
        #1;
        chk("rst_busy", longint'(bus.busy), 0);
        chk("rst_res_valid", longint'(bus.res_valid), 0);
        chk("rst_overrun", longint'(bus.overrun), 0);
        chk("rst_sum_p", longint'($signed(bus.sum_p)), 0);
        chk("rst_sum_vv", longint'(bus.sum_vv), 0);
        chk("rst_sum_ii", longint'(bus.sum_ii), 0);
`ifdef PEAK_EN
        chk("rst_v_pk", longint'(bus.v_pk), 0);
`endif
        @(negedge clk);
        rst = 0;
        model_reset();

        // Random strobes, values and occasional clr against the model
        for (int n = 0; n < 600; n++) begin
            c  = ($urandom_range(0, 59) == 0);
            s  = ($urandom_range(0, 2) == 0);
            rv = ($urandom_range(0, 7) == 0) ? 14'd0 : 14'($urandom);
            ri = ($urandom_range(0, 7) == 0) ? 14'd16383 : 14'($urandom);
            step(c, s, rv, ri);
        end

        // Long window of extreme negative samples: no wrap at 48 bits
        for (int n = 0; n < BIG_W; n++) begin
            @(negedge clk);
            bif.smp_valid = 1; bif.v_smp = '0; bif.i_smp = '0;
            @(negedge clk);
            bif.smp_valid = 0;
            repeat (3) @(negedge clk);
        end
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (bif.res_valid) seen = 1;
        end
        chk("big_res_valid_seen", longint'(seen), 1);
        $display("big window: sum_p=%0d sum_vv=%0d sum_ii=%0d", $signed(bif.sum_p), bif.sum_vv, bif.sum_ii);
        chk("big_sum_p", longint'($signed(bif.sum_p)), 64'sd137438953472);
        chk("big_sum_vv", longint'(bif.sum_vv), 64'sd137438953472);
        chk("big_sum_ii", longint'(bif.sum_ii), 64'sd137438953472);
        chk("big_overrun", longint'(bif.overrun), 0);
`ifdef PEAK_EN
        chk("big_v_pk", longint'(bif.v_pk), 8191);
        chk("big_i_pk", longint'(bif.i_pk), 8191);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
